// File: rtl/pattern_sequencer.sv
// Simon-style target sequence: appends one pad per round from the LFSR,
// plays the sequence back as timed highlights, then checks player guesses.
module pattern_sequencer #(
   parameter int MAX_LEN    = 16,
   parameter int IDX_WIDTH  = 2,
   parameter int ON_CYCLES  = 25_000_000,
   parameter int OFF_CYCLES = 12_500_000
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [15:0]                  rand_in,
   input  logic                         clear_in,
   input  logic                         new_round_in,
   input  logic                         guess_valid_in,
   input  logic [IDX_WIDTH-1:0]         guess_idx_in,
   output logic                         show_valid_out,
   output logic [IDX_WIDTH-1:0]         show_idx_out,
   output logic                         input_ready_out,
   output logic                         correct_out,
   output logic                         wrong_out,
   output logic                         round_done_out,
   output logic                         game_won_out,
   output logic [$clog2(MAX_LEN+1)-1:0] len_out
);

   localparam int LW   = $clog2(MAX_LEN + 1);
   localparam int PW   = $clog2(MAX_LEN);
   localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHOW_ON,
      S_SHOW_OFF,
      S_INPUT
   } state_t;

   state_t               r_state;
   logic [LW-1:0]        r_len;
   logic [PW-1:0]        r_ptr;
   logic [TW-1:0]        r_timer;
   logic [IDX_WIDTH-1:0] r_seq [MAX_LEN];

   logic                 r_show_valid;
   logic [IDX_WIDTH-1:0] r_show_idx;
   logic                 r_input_ready;
   logic                 r_correct;
   logic                 r_wrong;
   logic                 r_round_done;
   logic                 r_game_won;

   logic                 w_append;
   logic                 w_full;
   logic                 w_last;
   logic                 w_timer_zero;
   logic [PW-1:0]        w_ptr_inc;
   logic [IDX_WIDTH-1:0] w_rand_idx;
   logic [IDX_WIDTH-1:0] w_first_idx;
   logic                 w_unused;

   assign w_rand_idx   = rand_in[IDX_WIDTH-1:0];
   assign w_unused     = ^rand_in[15:IDX_WIDTH];
   assign w_full       = (r_len == LW'(MAX_LEN));
   assign w_append     = !rst_in && !clear_in && (r_state == S_IDLE)
                         && new_round_in && !w_full;
   assign w_last       = (LW'(r_ptr) == (r_len - LW'(1)));
   assign w_timer_zero = (r_timer == '0);
   assign w_ptr_inc    = r_ptr + PW'(1);
   // On the first round seq[0] is written on the same edge it is shown.
   assign w_first_idx  = (r_len == '0) ? w_rand_idx : r_seq[0];

   // Sequence storage: append the new pad index at position len.
   always_ff @(posedge clk_in) begin
      if (w_append) begin
         r_seq[r_len[PW-1:0]] <= w_rand_idx;
      end
   end

   // Main FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in || clear_in) begin
         r_state       <= S_IDLE;
         r_len         <= '0;
         r_ptr         <= '0;
         r_timer       <= '0;
         r_show_valid  <= 1'b0;
         r_show_idx    <= '0;
         r_input_ready <= 1'b0;
         r_correct     <= 1'b0;
         r_wrong       <= 1'b0;
         r_round_done  <= 1'b0;
         r_game_won    <= 1'b0;
      end else begin
         r_correct    <= 1'b0;
         r_wrong      <= 1'b0;
         r_round_done <= 1'b0;
         r_game_won   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (new_round_in) begin
                  if (w_full) begin
                     r_game_won <= 1'b1;
                  end else begin
                     r_len        <= r_len + LW'(1);
                     r_ptr        <= '0;
                     r_timer      <= TW'(ON_CYCLES - 1);
                     r_show_valid <= 1'b1;
                     r_show_idx   <= w_first_idx;
                     r_state      <= S_SHOW_ON;
                  end
               end
            end
            S_SHOW_ON: begin
               if (w_timer_zero) begin
                  r_timer      <= TW'(OFF_CYCLES - 1);
                  r_show_valid <= 1'b0;
                  r_show_idx   <= '0;
                  r_state      <= S_SHOW_OFF;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_SHOW_OFF: begin
               if (!w_timer_zero) begin
                  r_timer <= r_timer - TW'(1);
               end else if (!w_last) begin
                  r_ptr        <= w_ptr_inc;
                  r_timer      <= TW'(ON_CYCLES - 1);
                  r_show_valid <= 1'b1;
                  r_show_idx   <= r_seq[w_ptr_inc];
                  r_state      <= S_SHOW_ON;
               end else begin
                  r_ptr         <= '0;
                  r_timer       <= '0;
                  r_input_ready <= 1'b1;
                  r_state       <= S_INPUT;
               end
            end
            S_INPUT: begin
               if (guess_valid_in) begin
                  if (guess_idx_in == r_seq[r_ptr]) begin
                     r_correct <= 1'b1;
                     if (w_last) begin
                        r_round_done  <= 1'b1;
                        r_input_ready <= 1'b0;
                        r_ptr         <= '0;
                        r_state       <= S_IDLE;
                     end else begin
                        r_ptr <= w_ptr_inc;
                     end
                  end else begin
                     r_wrong       <= 1'b1;
                     r_input_ready <= 1'b0;
                     r_ptr         <= '0;
                     r_state       <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign show_valid_out  = r_show_valid;
   assign show_idx_out    = r_show_idx;
   assign input_ready_out = r_input_ready;
   assign correct_out     = r_correct;
   assign wrong_out       = r_wrong;
   assign round_done_out  = r_round_done;
   assign game_won_out    = r_game_won;
   assign len_out         = r_len;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with short timing parameters
// (MAX_LEN=4, ON=3, OFF=2).
module tb_pattern_sequencer;

   localparam int ML  = 4;
   localparam int IW  = 2;
   localparam int ON  = 3;
   localparam int OFF = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [15:0]   rnd = '0;
   logic          clr = 1'b0;
   logic          nr  = 1'b0;
   logic          gv  = 1'b0;
   logic [IW-1:0] gi  = '0;
   logic          sv;
   logic [IW-1:0] si;
   logic          rdy;
   logic          cor;
   logic          wrg;
   logic          rdn;
   logic          won;
   logic [2:0]    len;

   int n_tests = 0;
   int n_fail  = 0;
   logic [IW-1:0] m_seq [ML];

   pattern_sequencer #(
      .MAX_LEN(ML), .IDX_WIDTH(IW), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
   ) dut (
      .clk_in(clk), .rst_in(rst), .rand_in(rnd), .clear_in(clr),
      .new_round_in(nr), .guess_valid_in(gv), .guess_idx_in(gi),
      .show_valid_out(sv), .show_idx_out(si), .input_ready_out(rdy),
      .correct_out(cor), .wrong_out(wrg), .round_done_out(rdn),
      .game_won_out(won), .len_out(len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag, input int exp_len);
      chk({tag, " sv"}, sv, 0);
      chk({tag, " si"}, si, 0);
      chk({tag, " rdy"}, rdy, 0);
      chk({tag, " cor"}, cor, 0);
      chk({tag, " wrg"}, wrg, 0);
      chk({tag, " rdn"}, rdn, 0);
      chk({tag, " won"}, won, 0);
      chk({tag, " len"}, len, exp_len);
   endtask

   // Called on the first highlighted cycle; checks whole playback of n pads.
   task automatic play(input int n, input bit noise);
      for (int e = 0; e < n; e++) begin
         for (int c = 0; c < ON + OFF; c++) begin
            chk("play sv", sv, (c < ON) ? 1 : 0);
            chk("play si", si, (c < ON) ? int'(m_seq[e]) : 0);
            chk("play rdy", rdy, 0);
            chk("play cor", cor, 0);
            chk("play wrg", wrg, 0);
            gv = noise;
            gi = m_seq[e];
            tick();
         end
      end
      gv = 1'b0;
      chk("play rdy end", rdy, 1);
      chk("play cor end", cor, 0);
      chk("play wrg end", wrg, 0);
   endtask

   task automatic start_round(input logic [15:0] r);
      rnd = r;
      nr  = 1'b1;
      tick();
      nr  = 1'b0;
   endtask

   task automatic guess(input logic [IW-1:0] g, input int e_cor,
                        input int e_wrg, input int e_rdn, input int e_rdy);
      gv = 1'b1;
      gi = g;
      tick();
      gv = 1'b0;
      chk("guess cor", cor, e_cor);
      chk("guess wrg", wrg, e_wrg);
      chk("guess rdn", rdn, e_rdn);
      chk("guess rdy", rdy, e_rdy);
      tick();
      chk("pulse cor", cor, 0);
      chk("pulse wrg", wrg, 0);
      chk("pulse rdn", rdn, 0);
   endtask

   initial begin
      // 1: reset and first round
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk_idle("reset", 0);
      m_seq[0] = 2'd3;
      start_round(16'h0003);
      chk("r1 len", len, 1);
      play(1, 1'b0);

      // 2: correct final guess ends round
      guess(2'd3, 1, 0, 1, 0);
      chk("r1 len kept", len, 1);

      // 3: second round, guesses during playback ignored, then wrong guess
      m_seq[1] = 2'd2;
      start_round(16'hABC2);
      chk("r2 len", len, 2);
      play(2, 1'b1);
      guess(2'd3, 1, 0, 0, 1);
      // 6b: new_round during INPUT has no effect
      rnd = 16'h0001;
      nr  = 1'b1;
      tick();
      nr  = 1'b0;
      chk("nr input len", len, 2);
      chk("nr input sv", sv, 0);
      chk("nr input rdy", rdy, 1);
      guess(2'd1, 0, 1, 0, 0);
      chk("wrong len", len, 2);
      chk("wrong sv", sv, 0);

      // 4: full game to MAX_LEN, then game_won
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk_idle("clear", 0);
      for (int r = 0; r < ML; r++) begin
         m_seq[r] = IW'(r);
         start_round(16'(r));
         chk("g len", len, r + 1);
         play(r + 1, 1'b1);
         for (int k = 0; k <= r; k++) begin
            guess(m_seq[k], 1, 0, (k == r) ? 1 : 0, (k == r) ? 0 : 1);
         end
      end
      chk("full len", len, ML);
      start_round(16'h0002);
      chk("won", won, 1);
      chk("won len", len, ML);
      chk("won sv", sv, 0);
      tick();
      chk("won pulse", won, 0);
      chk("won sv2", sv, 0);
      chk("won len2", len, ML);

      // 5: clear during SHOW_ON, then rst together with clear
      clr = 1'b1;
      tick();
      clr = 1'b0;
      start_round(16'h0001);
      chk("c sv1", sv, 1);
      chk("c si1", si, 1);
      tick();
      chk("c sv2", sv, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk_idle("clr show", 0);
      tick();
      chk_idle("clr idle", 0);
      start_round(16'h0002);
      chk("rc sv", sv, 1);
      rst = 1'b1;
      clr = 1'b1;
      tick();
      rst = 1'b0;
      clr = 1'b0;
      chk_idle("rst+clr", 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
